// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller: FSM state
// codes, opcodes, funct3 values and datapath select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;

  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_OLDPC = 2'd1;
  localparam logic [1:0] SRC_A_RS1   = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_MEM    = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

endpackage

// File: rtl/branch_cond.sv
// Branch resolution: picks the ALU comparison flag that matches the branch
// funct3 and reports whether the branch is taken.
module branch_cond
  import ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  output logic       taken
);

  // Map each branch kind onto its flag (or its inverse)
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = alu_zero;
      F3_BNE:  taken = ~alu_zero;
      F3_BLT:  taken = alu_lt;
      F3_BGE:  taken = ~alu_lt;
      F3_BLTU: taken = alu_ltu;
      F3_BGEU: taken = ~alu_ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_multiciclo.sv
// Multicycle control FSM for the RV32I-subset datapath (add, sub, addi,
// branches, lw, sw). Data-memory accesses wait on mem_ready with an optional
// timeout (WAIT_LIMIT, 0 = wait forever). Illegal encodings and timeouts park
// the core in a sticky TRAP state until reset.
// Optional macro PERF_COUNTERS_EN adds cycle / retired-instruction counters;
// without it both counter ports are tied to zero.
module ctrl_multiciclo
  import ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 0,
  parameter int unsigned COUNTER_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 alu_zero,
  input  logic                 alu_lt,
  input  logic                 alu_ltu,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           result_src,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [3:0]           state_dbg,
  output logic [COUNTER_W-1:0] cycle_count,
  output logic [COUNTER_W-1:0] instret_count
);

  state_t      state, next_state;
  logic [31:0] wait_cnt;
  logic        illegal_q, bus_err_q;
  logic        taken;
  logic        wait_expired;

  branch_cond u_branch_cond (
    .funct3   (funct3),
    .alu_zero (alu_zero),
    .alu_lt   (alu_lt),
    .alu_ltu  (alu_ltu),
    .taken    (taken)
  );

  assign wait_expired = (WAIT_LIMIT != 0) && (wait_cnt == WAIT_LIMIT);
  assign state_dbg    = state;

  // Next-state and datapath controls; reset forces every output quiet
  always_comb begin
    next_state = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_ADD;
    result_src = RES_ALUOUT;
    illegal    = illegal_q;
    bus_err    = bus_err_q;
    case (state)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        if ((opcode == OP_LOAD || opcode == OP_STORE) && funct3 == F3_WORD)
          next_state = S_MEMADR;
        else if (opcode == OP_R && funct3 == F3_ADD)
          next_state = S_EXECR;
        else if (opcode == OP_I && funct3 == F3_ADD)
          next_state = S_EXECI;
        else if (opcode == OP_BRANCH && funct3 != 3'b010 && funct3 != 3'b011)
          next_state = S_BRANCH;
        else
          next_state = S_TRAP;
      end
      S_MEMADR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        if (mem_ready)         next_state = S_MEMWB;
        else if (wait_expired) next_state = S_TRAP;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        if (mem_ready)         next_state = S_FETCH;
        else if (wait_expired) next_state = S_TRAP;
      end
      S_EXECR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = {1'b0, funct7b5};
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_SUB;
        pc_write   = taken;
        next_state = S_FETCH;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_TRAP;
    endcase
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RS2;
      alu_op     = ALU_ADD;
      result_src = RES_ALUOUT;
      illegal    = 1'b0;
      bus_err    = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Memory wait counter: zero outside the wait states, counts not-ready cycles inside
  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt <= 32'd0;
    else if (state != S_MEMREAD && state != S_MEMWRITE)
      wait_cnt <= 32'd0;
    else if (!mem_ready)
      wait_cnt <= wait_cnt + 32'd1;
  end

  // Sticky trap cause flags
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (state == S_DECODE && next_state == S_TRAP)
        illegal_q <= 1'b1;
      if ((state == S_MEMREAD || state == S_MEMWRITE) && next_state == S_TRAP)
        bus_err_q <= 1'b1;
    end
  end

`ifdef PERF_COUNTERS_EN
  logic                 retire;
  logic [COUNTER_W-1:0] cycle_q, instret_q;

  assign retire = (next_state == S_FETCH) &&
                  (state == S_MEMWB || state == S_MEMWRITE ||
                   state == S_ALUWB || state == S_BRANCH);

  // Free-running cycle counter and retirement counter, both wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + COUNTER_W'(1);
      if (retire)
        instret_q <= instret_q + COUNTER_W'(1);
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`else
  assign cycle_count   = '0;
  assign instret_count = '0;
`endif

endmodule
